instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
// Instruction decode stage: a small FIFO of raw 16-bit words with a combinational
// decoder on the head entry and a RUN/HALTED state machine driven by HALT pops.
module instr_decode #(
  parameter int DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Instruction,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [3:0]  Opcode,
  output logic [3:0]  Rd,
  output logic [3:0]  Rs1,
  output logic [3:0]  Rs2,
  output logic [15:0] Imm,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Illegal,
  output logic        Halted,
  output logic        state_dbg
);

  // Handshakes: a word transfers on an edge where valid && ready are both 1;
  // ready never depends on valid, and the producer holds data while valid && !ready.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [15:0]     buf_q [DEPTH];
  logic [15:0]     buf_d [DEPTH];
  logic            halted_q, halted_d;

  logic            push;
  logic            pop;
  logic            halt_pop;
  logic [15:0]     head_w;

  assign head_w     = buf_q[head_q];
  assign InstrReady = (state_q == ST_RUN) && (count_q < CW'(DEPTH)) && !Flush;
  assign OutValid   = (state_q == ST_RUN) && (count_q != '0);
  assign push       = InstrValid && InstrReady;
  assign pop        = OutValid && OutReady && !Flush;
  assign halt_pop   = pop && (head_w[15:12] == 4'hF);
  assign Halted     = halted_q;
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    buf_d   = buf_q;
    if (push) begin
      buf_d[tail_q] = Instruction;
    end
    if (Flush) begin
      state_d = ST_RUN;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else if (halt_pop) begin
      // HALT is consumed and takes anything pushed alongside it down with the buffer.
      state_d = ST_HALTED;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
    end
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      halted_q <= halted_d;
    end
    buf_q <= buf_d;
  end

  always_comb begin
    Opcode   = '0;
    Rd       = '0;
    Rs1      = '0;
    Rs2      = '0;
    Imm      = '0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Illegal  = 1'b0;
    if (OutValid) begin
      Opcode = head_w[15:12];
      Rd     = head_w[11:8];
      Rs1    = head_w[7:4];
      Rs2    = head_w[3:0];
      Imm    = {{8{head_w[7]}}, head_w[7:0]};
      case (head_w[15:12])
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5: RegWrite = 1'b1;
        4'h6: begin
          RegWrite = 1'b1;
          MemRead  = 1'b1;
        end
        4'h7: MemWrite = 1'b1;
        4'h8, 4'h9: Branch = 1'b1;
        4'hA, 4'hB, 4'hC, 4'hD, 4'hE: Illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
